load_store_unit: RTL and testbench

Sits between the CPU execute stage and the word-addressed `memory` block (16-bit word address, 32-bit data, `wf` write-enable sampled at `clk` posedge, read data on `v`). Accepts byte-addressed load/store requests over a valid/ready handshake. Performs aligned byte, halfword and word accesses, using read-modify-write for sub-word stores. Returns one response per request, with load data extracted and sign/zero-extended.

---
 rtl/load_store_unit_if.sv | 38 +++
 rtl/load_store_unit.sv | 153 +++++++++++++++
 tb/tb_load_store_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response handshake and word-memory bus between the execute stage,
// the load/store unit and the word-addressed memory.
interface load_store_unit_if #(
  parameter int M = 16,
  parameter int N = 32
);
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [1:0]   req_size;
  logic         req_signed;
  logic [M+1:0] req_addr;
  logic [N-1:0] req_wdata;

  logic         resp_valid;
  logic         resp_ready;
  logic [N-1:0] resp_rdata;
  logic         resp_err;

  logic [M-1:0] mem_address;
  logic         mem_wf;
  logic [N-1:0] mem_w;
  logic [N-1:0] mem_v;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready, mem_v,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_address, mem_wf, mem_w
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output resp_ready, mem_v,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_address, mem_wf, mem_w
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a 32-bit word memory: aligned
// byte/half/word accesses, read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int M       = 16,
  parameter int N       = 32,
  parameter int RD_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]   state;
  logic [2:0]   cnt;
  logic [M-1:0] mem_address;
  logic         mem_wf;
  logic [N-1:0] mem_w;
  logic         resp_valid;
  logic [N-1:0] resp_rdata;
  logic         resp_err;

  logic         we_p0;
  logic [1:0]   size_p0;
  logic         sgn_p0;
  logic [1:0]   off_p0;
  logic [N-1:0] wdata_p0;
  logic         bad;

  function automatic logic [N-1:0] extend_load(input logic [N-1:0] word,
                                               input logic [1:0]   size,
                                               input logic [1:0]   off,
                                               input logic         sgn);
    logic [N-1:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'd0:    return {{(N-8){sgn & sh[7]}}, sh[7:0]};
      2'd1:    return {{(N-16){sgn & sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [N-1:0] merge_lanes(input logic [N-1:0] word,
                                               input logic [N-1:0] wdata,
                                               input logic [1:0]   size,
                                               input logic [1:0]   off);
    logic [N-1:0] mask;
    logic [N-1:0] ins;
    mask = (size == 2'd0) ? {{(N-8){1'b0}}, 8'hff} : {{(N-16){1'b0}}, 16'hffff};
    mask = mask << {off, 3'b000};
    ins  = wdata << {off, 3'b000};
    return (word & ~mask) | (ins & mask);
  endfunction

  always_comb begin
    bad = 1'b0;
    case (bus.req_size)
      2'd1:    bad = bus.req_addr[0];
      2'd2:    bad = |bus.req_addr[1:0];
      2'd3:    bad = 1'b1;
      default: bad = 1'b0;
    endcase
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.mem_address = mem_address;
  assign bus.mem_wf      = mem_wf;
  assign bus.mem_w       = mem_w;
  assign bus.resp_valid  = resp_valid;
  assign bus.resp_rdata  = resp_rdata;
  assign bus.resp_err    = resp_err;

  // p0: request fields captured at accept, held for the whole transaction
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req_valid) begin
      we_p0    <= bus.req_we;
      size_p0  <= bus.req_size;
      sgn_p0   <= bus.req_signed;
      off_p0   <= bus.req_addr[1:0];
      wdata_p0 <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      mem_address <= '0;
      mem_wf      <= 1'b0;
      mem_w       <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (bad) begin
              state      <= RESP;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              mem_address <= bus.req_addr[M+1:2];
              if (bus.req_we && bus.req_size == 2'd2) begin
                state  <= WRITE;
                mem_wf <= 1'b1;
                mem_w  <= bus.req_wdata;
              end else begin
                state <= READ;
                cnt   <= 3'(RD_WAIT - 1);
              end
            end
          end
        end
        READ: begin
          if (cnt == '0) begin
            if (we_p0) begin
              state  <= WRITE;
              mem_wf <= 1'b1;
              mem_w  <= merge_lanes(bus.mem_v, wdata_p0, size_p0, off_p0);
            end else begin
              state      <= RESP;
              resp_rdata <= extend_load(bus.mem_v, size_p0, off_p0, sgn_p0);
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        WRITE: begin
          mem_wf     <= 1'b0;
          resp_rdata <= '0;
          state      <= RESP;
        end
        default: begin
          // First RESP cycle raises valid; data/err were loaded on entry.
          if (!resp_valid) begin
            resp_valid <= 1'b1;
          end else if (bus.resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            state      <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized requests
// checked against an arithmetic reference model of the memory and responses.
module tb_load_store_unit;
  localparam int M       = 16;
  localparam int N       = 32;
  localparam int RD_WAIT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.M(M), .N(N)) bus ();

  load_store_unit #(.M(M), .N(N), .RD_WAIT(RD_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [31:0] mem     [0:65535] = '{default: 32'h0};
  logic [31:0] ref_mem [0:65535] = '{default: 32'h0};
  int          wf_cnt  = 0;
  logic [15:0] wf_addr = '0;
  logic [31:0] wf_data = '0;

  assign bus.mem_v = mem[bus.mem_address];

  always @(posedge clk) begin
    if (bus.mem_wf) begin
      mem[bus.mem_address] <= bus.mem_w;
      wf_cnt               <= wf_cnt + 1;
      wf_addr              <= bus.mem_address;
      wf_data              <= bus.mem_w;
    end
  end

  int vec  = 0;
  int miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: pure arithmetic on byte lanes; updates ref_mem for stores.
  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [17:0] addr, input logic [31:0] wdata,
                       output logic [31:0] e_rdata, output logic e_err,
                       output int e_lat, output int e_wf);
    longint w, span, v, old, nw;
    int     off, sh, bytes, idx;
    idx   = int'(addr) / 4;
    off   = int'(addr) % 4;
    sh    = 8 * off;
    w     = longint'(ref_mem[idx]);
    bytes = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    span  = longint'(1) << (8 * bytes);
    e_rdata = 32'h0; e_err = 1'b0; e_wf = 0; e_lat = 0;
    if (size == 3 || (size == 1 && (int'(addr) % 2) != 0) || (size == 2 && off != 0)) begin
      e_err = 1'b1;
      e_lat = 1;
    end else if (!we) begin
      v = (w >> sh) % span;
      if (sgn && bytes < 4 && v >= span / 2) v = v - span;
      e_rdata = 32'(v);
      e_lat   = 1 + RD_WAIT;
    end else begin
      old = (w >> sh) % span;
      nw  = w - (old << sh) + ((longint'(wdata) % span) << sh);
      ref_mem[idx] = 32'(nw);
      e_wf  = 1;
      e_lat = (bytes == 4) ? 2 : 2 + RD_WAIT;
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [17:0] addr, input logic [31:0] wdata,
                        input int hold, output logic [31:0] got);
    logic [31:0] e_rdata, snap;
    logic        e_err;
    int          e_lat, e_wf, wf0, lat;
    model(we, size, sgn, addr, wdata, e_rdata, e_err, e_lat, e_wf);
    @(negedge clk);
    chk("req_ready_idle", bus.req_ready, 1);
    wf0            = wf_cnt;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.resp_valid && lat < 30) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", lat, e_lat);
    chk("resp_rdata", bus.resp_rdata, e_rdata);
    chk("resp_err", bus.resp_err, e_err);
    chk("wf_pulses", wf_cnt - wf0, e_wf);
    chk("mem_word", mem[addr[17:2]], ref_mem[addr[17:2]]);
    snap = bus.resp_rdata;
    got  = snap;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", bus.resp_valid, 1);
      chk("hold_rdata", bus.resp_rdata, snap);
      chk("hold_req_ready", bus.req_ready, 0);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_valid", bus.resp_valid, 0);
    chk("release_req_ready", bus.req_ready, 1);
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int          wf_before;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_mem_wf", bus.mem_wf, 0);
    chk("rst_mem_address", bus.mem_address, 0);
    chk("rst_mem_w", bus.mem_w, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_req(1'b1, 2'd2, 1'b0, 18'h00004, 32'hcafebabe, 0, got);
    chk("ws_addr", wf_addr, 16'h0001);
    chk("ws_data", wf_data, 32'hcafebabe);
    do_req(1'b0, 2'd2, 1'b0, 18'h00004, 32'h0, 0, got);
    chk("lw_data", got, 32'hcafebabe);

    do_req(1'b1, 2'd0, 1'b0, 18'h00006, 32'h00000011, 0, got);
    chk("sb_mem", mem[1], 32'hca11babe);
    do_req(1'b0, 2'd0, 1'b0, 18'h00006, 32'h0, 0, got);
    chk("lbu_data", got, 32'h00000011);

    do_req(1'b1, 2'd2, 1'b0, 18'h3fffc, 32'hdeadbeef, 0, got);
    do_req(1'b0, 2'd1, 1'b1, 18'h3fffe, 32'h0, 0, got);
    chk("lh_signed", got, 32'hffffdead);
    do_req(1'b0, 2'd1, 1'b0, 18'h3fffe, 32'h0, 0, got);
    chk("lh_unsigned", got, 32'h0000dead);
    do_req(1'b0, 2'd0, 1'b1, 18'h3fffc, 32'h0, 0, got);
    chk("lb_signed", got, 32'hffffffef);

    do_req(1'b0, 2'd2, 1'b0, 18'h00002, 32'h0, 0, got);
    do_req(1'b1, 2'd1, 1'b0, 18'h00005, 32'h12345678, 0, got);
    chk("mis_mem_unchanged", mem[1], 32'hca11babe);
    do_req(1'b1, 2'd3, 1'b0, 18'h00004, 32'h0badf00d, 0, got);

    do_req(1'b0, 2'd2, 1'b0, 18'h00004, 32'h0, 5, got);
    chk("bp_data", got, 32'hca11babe);

    // Reset while a byte store is still reading its target word.
    wf_before = wf_cnt;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 18'h00006;
    bus.req_wdata  = 32'h00000077;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_resp_valid", bus.resp_valid, 0);
    chk("mid_rst_mem_wf", bus.mem_wf, 0);
    chk("mid_rst_mem_address", bus.mem_address, 0);
    chk("mid_rst_mem_w", bus.mem_w, 0);
    chk("mid_rst_req_ready", bus.req_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_mem_word", mem[1], 32'hca11babe);
    chk("mid_rst_no_wf", wf_cnt - wf_before, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 2'd0, 1'b0, 18'h00006, 32'h0, 0, got);
    chk("post_rst_load", got, 32'h00000011);

    for (int i = 0; i < 16; i++)
      do_req(1'b1, 2'd2, 1'b0, 18'(32'h400 + 4 * i), $urandom, 0, got);
    for (int i = 0; i < 40; i++)
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             18'(32'h400 + $urandom_range(0, 63)), $urandom, int'($urandom_range(0, 2)), got);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
